// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - fetch-stage PC unit bus: cache hit, redirect request, PC outputs
interface pc_fetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             hit;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic [WIDTH-1:0] instruction_address;
  logic [WIDTH-1:0] next_sequential;
  logic             redirect_pending;
  logic             stalled;
  logic [31:0]      stall_count;

  // The PC unit masters the I-cache address port.
  modport master (
    input  hit,
    input  redirect_valid,
    input  redirect_target,
    output instruction_address,
    output next_sequential,
    output redirect_pending,
    output stalled,
    output stall_count
  );

  modport slave (
    output hit,
    output redirect_valid,
    output redirect_target,
    input  instruction_address,
    input  next_sequential,
    input  redirect_pending,
    input  stalled,
    input  stall_count
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch PC register with miss stall and buffered redirect
// Optional miss-cycle counter enabled by PC_STALL_COUNT_EN.
module pc_fetch_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INCREMENT    = 4
) (
  input  logic             clock,
  input  logic             reset,
  pc_fetch_unit_if.master  bus
);
  localparam logic [WIDTH-1:0] INC = WIDTH'(INCREMENT);

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    MISS       = 2'd1,
    MISS_REDIR = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             pending_q, pending_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_VECTOR;
      target_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      target_q  <= target_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    target_d  = target_q;
    pending_d = pending_q;
    if (bus.hit) begin
      state_d   = FETCH;
      pending_d = 1'b0;
      // A fresh redirect outranks the buffered one; both outrank sequential flow.
      if (bus.redirect_valid) begin
        pc_d = bus.redirect_target;
      end else if (pending_q) begin
        pc_d = target_q;
      end else begin
        pc_d = pc_q + INC;
      end
    end else begin
      state_d = (pending_q || bus.redirect_valid) ? MISS_REDIR : MISS;
      if (bus.redirect_valid) begin
        target_d  = bus.redirect_target;
        pending_d = 1'b1;
      end
    end
  end

  assign bus.instruction_address = pc_q;
  assign bus.next_sequential     = pc_q + INC;
  assign bus.redirect_pending    = pending_q;
  assign bus.stalled             = (state_q != FETCH);

`ifdef PC_STALL_COUNT_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (!bus.hit && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall_count = stall_count_q;
`else
  assign bus.stall_count = '0;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
  logic clock;
  logic reset;
  int   total;
  int   bad;

`ifdef PC_STALL_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  pc_fetch_unit_if #(.WIDTH(32)) bus ();

  pc_fetch_unit #(
    .WIDTH(32),
    .RESET_VECTOR(32'h0),
    .INCREMENT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] cnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.hit = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;
    tick();
    check("rst_pc", bus.instruction_address, 32'h0);
    check("rst_ns", bus.next_sequential, 32'h4);
    check("rst_pend", 32'(bus.redirect_pending), 32'd0);
    check("rst_stall", 32'(bus.stalled), 32'd0);
    check("rst_cnt", bus.stall_count, 32'd0);

    reset = 1'b0;
    bus.hit = 1'b1;
    tick();
    check("seq_pc1", bus.instruction_address, 32'h4);
    tick();
    check("seq_pc2", bus.instruction_address, 32'h8);
    tick();
    check("seq_pc3", bus.instruction_address, 32'hC);
    check("seq_ns3", bus.next_sequential, 32'h10);
    check("seq_stall", 32'(bus.stalled), 32'd0);

    bus.hit = 1'b0;
    tick();
    check("miss_pc1", bus.instruction_address, 32'hC);
    check("miss_st1", 32'(bus.stalled), 32'd1);
    tick();
    check("miss_pc2", bus.instruction_address, 32'hC);
    check("miss_st2", 32'(bus.stalled), 32'd1);
    check("miss_pend", 32'(bus.redirect_pending), 32'd0);
    bus.hit = 1'b1;
    tick();
    check("miss_pc3", bus.instruction_address, 32'h10);
    check("miss_st3", 32'(bus.stalled), 32'd0);
    check("miss_cnt", bus.stall_count, cnt(2));

    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h100;
    tick();
    check("redir_pc", bus.instruction_address, 32'h100);
    check("redir_pend", 32'(bus.redirect_pending), 32'd0);

    bus.hit = 1'b0;
    bus.redirect_target = 32'h200;
    tick();
    check("buf_pend1", 32'(bus.redirect_pending), 32'd1);
    check("buf_st1", 32'(bus.stalled), 32'd1);
    check("buf_pc1", bus.instruction_address, 32'h100);
    bus.redirect_target = 32'h300;
    tick();
    check("buf_pend2", 32'(bus.redirect_pending), 32'd1);
    check("buf_pc2", bus.instruction_address, 32'h100);
    bus.hit = 1'b1;
    bus.redirect_valid = 1'b0;
    tick();
    check("buf_pc3", bus.instruction_address, 32'h300);
    check("buf_pend3", 32'(bus.redirect_pending), 32'd0);
    check("buf_st3", 32'(bus.stalled), 32'd0);
    check("buf_cnt", bus.stall_count, cnt(4));

    bus.hit = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h200;
    tick();
    check("prio_pend1", 32'(bus.redirect_pending), 32'd1);
    bus.hit = 1'b1;
    bus.redirect_target = 32'h400;
    tick();
    check("prio_pc", bus.instruction_address, 32'h400);
    check("prio_pend2", 32'(bus.redirect_pending), 32'd0);

    bus.redirect_target = 32'hFFFF_FFFC;
    tick();
    check("wrap_pc1", bus.instruction_address, 32'hFFFF_FFFC);
    check("wrap_ns", bus.next_sequential, 32'h0);
    bus.redirect_valid = 1'b0;
    tick();
    check("wrap_pc2", bus.instruction_address, 32'h0);

    bus.hit = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h500;
    tick();
    check("mr_pend", 32'(bus.redirect_pending), 32'd1);
    check("mr_cnt", bus.stall_count, cnt(6));
    bus.redirect_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("mrrst_pc", bus.instruction_address, 32'h0);
    check("mrrst_pend", 32'(bus.redirect_pending), 32'd0);
    check("mrrst_st", 32'(bus.stalled), 32'd0);
    check("mrrst_cnt", bus.stall_count, 32'd0);
    reset = 1'b0;
    bus.hit = 1'b1;
    tick();
    check("post_rst_pc", bus.instruction_address, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
